// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the single-master bus controller.
//   region_t : slave region selected by cpu_addr[31:16]
//   state_t  : transaction FSM states
//   BASE_*   : region base values of cpu_addr[31:16]
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    REG_BRAM,
    REG_SRAM,
    REG_FLASH,
    REG_MMIO,
    REG_NONE
  } region_t;

  localparam logic [15:0] BASE_BRAM  = 16'h0000;
  localparam logic [15:0] BASE_SRAM  = 16'h0001;
  localparam logic [15:0] BASE_FLASH = 16'h0002;
  localparam logic [15:0] BASE_MMIO  = 16'h0003;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/bus_decode.sv
// ---------------------------------------------------------------------------
// bus_decode
// Combinational region decoder, shared with the top level.
// Ports:
//   region_bits in  16  cpu_addr[31:16]
//   region      out     decoded slave region, REG_NONE when unmapped
// ---------------------------------------------------------------------------
module bus_decode
  import bus_pkg::*;
(
  input  logic [15:0] region_bits,
  output region_t     region
);

  always_comb begin
    region = REG_NONE;
    case (region_bits)
      BASE_BRAM:  region = REG_BRAM;
      BASE_SRAM:  region = REG_SRAM;
      BASE_FLASH: region = REG_FLASH;
      BASE_MMIO:  region = REG_MMIO;
      default:    region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl
// Single-master bus controller between the cpu and the bram/sram/flash/mmio
// slaves. Decodes the region, issues a one-cycle per-slave strobe, waits for
// flash busy / mmio ready, and returns registered read data with ack/err.
//
// Optional build macro: BUS_CTRL_TIMEOUT_EN
//   defined   : BUSY and WAIT abort with cpu_err after TIMEOUT_CYCLES cycles
//   undefined : BUSY and WAIT wait indefinitely
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata       cpu request side
//   cpu_ready/ack/err/rdata     cpu response side
//   slv_addr, slv_wdata         latched offset and write data to all slaves
//   <slave>_rd_en/_wr_en        one-cycle strobes, one slave at a time
//   <slave>_rdata               slave read data, sampled only in WAIT
//   flash_busy, mmio_ready      slave flow control
// ---------------------------------------------------------------------------
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [15:0]       slv_addr,
  output logic [DATA_W-1:0] slv_wdata,
  output logic              bram_rd_en,
  output logic              bram_wr_en,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              flash_rd_en,
  output logic              flash_wr_en,
  input  logic              flash_busy,
  input  logic [DATA_W-1:0] flash_rdata,
  output logic              mmio_rd_en,
  output logic              mmio_wr_en,
  input  logic              mmio_ready,
  input  logic [DATA_W-1:0] mmio_rdata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_ctrl: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t            state_q, state_d;
  region_t           region_in, region_q;
  logic              we_q;
  logic              ready_q;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_sel;
  logic              accept, capture, timeout_hit;

  bus_decode u_decode (
    .region_bits (cpu_addr[31:16]),
    .region      (region_in)
  );

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q;

  // Counts cycles spent in BUSY/WAIT; restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if ((state_q == BUSY || state_q == WAIT) && state_d == state_q) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign timeout_hit = (wait_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    rdata_sel = bram_rdata;
    case (region_q)
      REG_SRAM:  rdata_sel = sram_rdata;
      REG_FLASH: rdata_sel = flash_rdata;
      REG_MMIO:  rdata_sel = mmio_rdata;
      default:   rdata_sel = bram_rdata;
    endcase
  end

  // Next-state logic. The "condition met" branches are tested before the
  // timeout so a slave that answers in the last allowed cycle still succeeds.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && ready_q) begin
          accept = 1'b1;
          err_d  = 1'b0;
          if (region_in == REG_NONE) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (region_in == REG_FLASH && flash_busy) begin
            state_d = BUSY;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      BUSY: begin
        if (!flash_busy) begin
          state_d = ISSUE;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (region_q != REG_MMIO || mmio_ready) begin
          state_d = RESP;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ready_q keeps cpu_ready low during reset and for no longer than that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      region_q  <= REG_NONE;
      we_q      <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
      if (accept) begin
        region_q  <= region_in;
        we_q      <= cpu_we;
        slv_addr  <= cpu_addr[15:0];
        slv_wdata <= cpu_wdata;
        rdata_q   <= '0;
      end else if (capture && !we_q) begin
        rdata_q <= rdata_sel;
      end
    end
  end

  assign cpu_ready   = (state_q == IDLE) && ready_q;
  assign cpu_ack     = (state_q == RESP);
  assign cpu_err     = (state_q == RESP) && err_q;
  assign cpu_rdata   = (state_q == RESP) ? rdata_q : '0;

  assign bram_rd_en  = (state_q == ISSUE) && (region_q == REG_BRAM)  && !we_q;
  assign bram_wr_en  = (state_q == ISSUE) && (region_q == REG_BRAM)  &&  we_q;
  assign sram_rd_en  = (state_q == ISSUE) && (region_q == REG_SRAM)  && !we_q;
  assign sram_wr_en  = (state_q == ISSUE) && (region_q == REG_SRAM)  &&  we_q;
  assign flash_rd_en = (state_q == ISSUE) && (region_q == REG_FLASH) && !we_q;
  assign flash_wr_en = (state_q == ISSUE) && (region_q == REG_FLASH) &&  we_q;
  assign mmio_rd_en  = (state_q == ISSUE) && (region_q == REG_MMIO)  && !we_q;
  assign mmio_wr_en  = (state_q == ISSUE) && (region_q == REG_MMIO)  &&  we_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_ctrl
// Self-checking bench for bus_ctrl: directed cases plus randomized
// transactions, each checked against expectations derived from the
// transaction rules (latency, strobe, data, error) with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_bus_ctrl;

  localparam int T = 4;
`ifdef BUS_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic [15:0] slv_addr;
  logic [31:0] slv_wdata;
  logic        bram_rd_en, bram_wr_en, sram_rd_en, sram_wr_en;
  logic        flash_rd_en, flash_wr_en, mmio_rd_en, mmio_wr_en;
  logic [31:0] bram_rdata, sram_rdata, flash_rdata, mmio_rdata;
  logic        flash_busy, mmio_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .bram_rd_en(bram_rd_en), .bram_wr_en(bram_wr_en), .bram_rdata(bram_rdata),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_rdata(sram_rdata),
    .flash_rd_en(flash_rd_en), .flash_wr_en(flash_wr_en), .flash_busy(flash_busy),
    .flash_rdata(flash_rdata),
    .mmio_rd_en(mmio_rd_en), .mmio_wr_en(mmio_wr_en), .mmio_ready(mmio_ready),
    .mmio_rdata(mmio_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit order: {mmio_wr, mmio_rd, flash_wr, flash_rd, sram_wr, sram_rd, bram_wr, bram_rd}
  function automatic logic [7:0] en_vec();
    return {mmio_wr_en, mmio_rd_en, flash_wr_en, flash_rd_en,
            sram_wr_en, sram_rd_en, bram_wr_en, bram_rd_en};
  endfunction

  // One transaction. Cycle 0 is the accept cycle; flash_busy is high in
  // cycles [0, busy_n) and mmio_ready is high from cycle rdy_at onward.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int busy_n, input int rdy_at);
    logic [15:0] hi;
    logic [31:0] sdata, rd_e, got_rd, got_sw;
    logic [15:0] got_sa;
    logic [7:0]  en_e, en_seen;
    bit          err_e, has_en, got_err;
    int          issue_c, ack_c, got_ack, en_c, en_cnt;

    hi      = addr[31:16];
    err_e   = 1'b0;
    has_en  = 1'b1;
    issue_c = 1;
    ack_c   = 3;
    sdata   = '0;
    case (hi)
      16'h0000: sdata = bram_rdata;
      16'h0001: sdata = sram_rdata;
      16'h0002: begin
        sdata = flash_rdata;
        if (TO_EN && busy_n > T) begin
          has_en = 1'b0; err_e = 1'b1; ack_c = T + 1;
        end else begin
          issue_c = busy_n + 1; ack_c = issue_c + 2;
        end
      end
      16'h0003: begin
        sdata = mmio_rdata;
        if (TO_EN && rdy_at > T + 1) begin
          err_e = 1'b1; ack_c = T + 2;
        end else begin
          ack_c = ((rdy_at > 2) ? rdy_at : 2) + 1;
        end
      end
      default: begin
        has_en = 1'b0; err_e = 1'b1; ack_c = 1;
      end
    endcase
    if (!has_en) issue_c = -1;
    en_e = has_en ? 8'(1 << (int'(hi) * 2 + int'(we))) : 8'h00;
    rd_e = (!we && !err_e) ? sdata : 32'h0;

    @(negedge clk);
    chk({name, ":ready"}, cpu_ready, 1'b1);
    chk({name, ":idle_ack"}, cpu_ack, 1'b0);
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    flash_busy = (busy_n > 0);
    mmio_ready = (rdy_at <= 0);

    got_ack = -1; got_err = 1'b0; got_rd = '0; got_sa = '0; got_sw = '0;
    en_c = -1; en_cnt = 0; en_seen = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (en_vec() != 8'h00) begin
        en_cnt++;
        en_c    = c;
        en_seen = en_seen | en_vec();
      end
      if (cpu_ack) begin
        got_ack = c; got_err = cpu_err; got_rd = cpu_rdata;
        got_sa  = slv_addr; got_sw = slv_wdata;
        cpu_req = 1'b0;
        break;
      end
      // Scramble cpu inputs to show they are ignored mid-transaction.
      cpu_req    = 1'($urandom_range(0, 1));
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = $urandom;
      cpu_wdata  = $urandom;
      flash_busy = (c < busy_n) || (issue_c > 0 && c > issue_c && $urandom_range(0, 1) == 1);
      mmio_ready = (c >= rdy_at);
    end
    cpu_req = 1'b0; flash_busy = 1'b0; mmio_ready = 1'b0;

    chk({name, ":ack_cycle"}, got_ack, ack_c);
    chk({name, ":err"}, got_err, err_e);
    chk({name, ":rdata"}, got_rd, rd_e);
    chk({name, ":en_which"}, en_seen, en_e);
    chk({name, ":en_cycle"}, en_c, issue_c);
    chk({name, ":en_count"}, en_cnt, has_en ? 1 : 0);
    chk({name, ":slv_addr"}, got_sa, addr[15:0]);
    chk({name, ":slv_wdata"}, got_sw, wd);
  endtask

  initial begin
    logic [15:0] hi;
    int          r;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flash_busy = 1'b0; mmio_ready = 1'b0;
    bram_rdata = '0; sram_rdata = '0; flash_rdata = '0; mmio_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst:ready", cpu_ready, 1'b0);
    chk("rst:ack", cpu_ack, 1'b0);
    chk("rst:err", cpu_err, 1'b0);
    chk("rst:rdata", cpu_rdata, 32'h0);
    chk("rst:slv_addr", slv_addr, 16'h0);
    chk("rst:slv_wdata", slv_wdata, 32'h0);
    chk("rst:enables", en_vec(), 8'h00);
    rst = 1'b0;

    // Directed cases
    bram_rdata = 32'hDEADBEEF; sram_rdata = 32'hA5A5A5A5;
    flash_rdata = 32'hF1A5F1A5; mmio_rdata = 32'h0BADF00D;
    run_txn("bram_rd", 1'b0, 32'h0000_0010, 32'h0, 0, 0);
    run_txn("sram_wr", 1'b1, 32'h0001_0004, 32'h12345678, 0, 0);
    run_txn("flash_busy5", 1'b0, 32'h0002_0100, 32'h0, 5, 0);
    run_txn("flash_busy4", 1'b0, 32'h0002_0104, 32'h0, 4, 0);
    run_txn("unmapped", 1'b0, 32'h0007_0000, 32'h0, 0, 0);
    run_txn("mmio_rdy10", 1'b0, 32'h0003_0008, 32'h0, 0, 10);
    run_txn("mmio_rdy5", 1'b0, 32'h0003_000C, 32'h0, 0, 5);
    run_txn("mmio_never", 1'b0, 32'h0003_0010, 32'h0, 0, TO_EN ? 1000 : 7);
    run_txn("mmio_wr", 1'b1, 32'h0003_0014, 32'hCAFEF00D, 0, 1);

    // Reset during the WAIT of an mmio read
    @(negedge clk);
    chk("rstw:ready", cpu_ready, 1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0003_0020; cpu_wdata = 32'h55;
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw:enables", en_vec(), 8'h00);
    chk("rstw:ack", cpu_ack, 1'b0);
    chk("rstw:ready", cpu_ready, 1'b0);
    chk("rstw:slv_addr", slv_addr, 16'h0);
    mmio_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw:post_ack", cpu_ack, 1'b0);
      chk("rstw:post_ready", cpu_ready, 1'b1);
    end
    mmio_ready = 1'b0;

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 4);
      hi = (r < 4) ? 16'(r) : 16'($urandom_range(4, 65535));
      bram_rdata = $urandom; sram_rdata = $urandom;
      flash_rdata = $urandom; mmio_rdata = $urandom;
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
              {hi, 16'($urandom)}, $urandom,
              $urandom_range(0, 7), $urandom_range(1, 12));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
Single-master bus controller between the cpu and the memory/peripheral slaves (bram, sram, flash, mmio).
- Decodes cpu address[31:16] into a region.
- Drives a one-cycle per-slave read/write enable.
- Inserts wait states for flash busy and mmio ready.
- Returns registered read data with an ack/err handshake.
- Replaces the free-running shared rd/wr enables and the combinational read-mux in the top level.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, cpu address width; bits [31:16] are the region, bits [15:0] the slave offset.
- TIMEOUT_CYCLES, 256, wait-state limit before error; used only with BUS_CTRL_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  transaction request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  controller idle; request accepted when cpu_req&&cpu_ready.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ack: unmapped address or timeout.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack.
- slv_addr  out  16  latched offset, cpu_addr[15:0]; the top level slices [11:0] for flash.
- slv_wdata  out  DATA_W  latched write data.
- bram_rd_en, bram_wr_en  out  1  bram strobes.
- bram_rdata  in  DATA_W
- sram_rd_en, sram_wr_en  out  1  sram strobes.
- sram_rdata  in  DATA_W
- flash_rd_en, flash_wr_en  out  1  flash strobes.
- flash_busy  in  1
- flash_rdata  in  DATA_W
- mmio_rd_en, mmio_wr_en  out  1  mmio strobes.
- mmio_ready  in  1
- mmio_rdata  in  DATA_W

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registered outputs go to 0: enables, cpu_ack, cpu_err, cpu_rdata, slv_addr, slv_wdata.
  - cpu_ready=0 while rst=1; cpu_ready=1 from the first cycle after release.
  - Reset mid-transaction aborts it silently; no ack is issued.
- Region decode on cpu_addr[31:16]: 0x0000 bram, 0x0001 sram, 0x0002 flash, 0x0003 mmio, anything else NONE.
- FSM states: IDLE, BUSY, ISSUE, WAIT, RESP.
- IDLE:
  - cpu_ready=1.
  - On accept, latch the address offset, we, wdata and region.
  - Next state: NONE goes to RESP with err=1; flash with flash_busy=1 goes to BUSY; otherwise ISSUE.
- BUSY: stay while flash_busy=1; go to ISSUE in the cycle after flash_busy is sampled 0.
- ISSUE:
  - Exactly one of the eight enables is high, for exactly one cycle.
  - rd_en when we=0, wr_en when we=1.
  - Next state is WAIT.
- WAIT:
  - bram/sram/flash: the slave responds with 1-cycle latency. Capture its rdata (reads) and go to RESP.
  - mmio: stay until mmio_ready=1, then capture mmio_rdata (reads) and go to RESP. mmio_ready asserted during ISSUE is ignored.
- RESP:
  - cpu_ack=1 for one cycle.
  - cpu_rdata = captured data on a read; 0 on a write or on error.
  - Next state is IDLE.
  - cpu_ready=0 during RESP, so back-to-back requests are spaced by one IDLE cycle.
- Latency, request accept to ack, for bram/sram/idle flash (read or write): 3 cycles (ISSUE, WAIT, RESP). Unmapped: 1 cycle.
- Input behaviour:
  - cpu_req and cpu inputs are ignored outside IDLE; latched values are stable for the whole transaction.
  - Slave rdata is not sampled except in WAIT.
  - flash_busy rising during WAIT is ignored, since the write was already issued.
- Outputs are combinational from state only; no combinational path from cpu_req.

Optional Feature:
BUS_CTRL_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY or WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES-1 with the condition still unmet, go to RESP with cpu_err=1 and cpu_rdata=0.
  - A flash access that times out in BUSY never asserts its enable.
- Undefined: no counter; BUSY and WAIT wait indefinitely, and cpu_err only flags unmapped addresses.

Decomposition:
- Package bus_pkg:
  - region_t enum: REG_BRAM, REG_SRAM, REG_FLASH, REG_MMIO, REG_NONE.
  - Region base constants (16'h0000–16'h0003).
  - state_t enum.
- Sub-module bus_decode: combinational, cpu_addr[31:16] -> region_t. It is reused by the top level for any future read-mux.

Test Plan:
- bram read at 0x0000_0010, bram_rdata=0xDEADBEEF -> bram_rd_en high only in cycle 1; cpu_ack with rdata 0xDEADBEEF, err=0, in cycle 3.
- sram write 0x0001_0004 data 0x12345678 -> sram_wr_en one pulse, slv_addr=0x0004, slv_wdata=0x12345678; ack in cycle 3 with rdata 0.
- flash read at 0x0002_0100 with flash_busy high 5 cycles -> no flash_rd_en while busy; enable pulses in the cycle after busy drops; ack 2 cycles later.
- Read at 0x0007_0000 -> no enable ever asserted; ack with err=1 in the cycle after accept.
- mmio read with mmio_ready after 10 cycles -> ack the cycle after ready, rdata=mmio_rdata. With BUS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4 and ready never asserted -> err=1 after 4 WAIT cycles.
- rst asserted during WAIT of an mmio access -> all enables and cpu_ack drop immediately; no ack after release; cpu_ready=1 the cycle after rst drops.
